// File: rtl/pipeline_hazard_sequencer_if.sv
// Decode-stage hazard inputs and pipeline register controls shared between
// the pipeline datapath (master) and its hazard sequencer (slave).
interface pipeline_hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             ID_stall;
  logic             ID_PCSrc;
  logic             MEM_busy;
  logic             Halt_req;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             MEM_WB_Write;
  logic             Halted;
  logic             Stall_timeout;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_stall, ID_PCSrc, MEM_busy, Halt_req,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write,
           EX_MEM_Write, MEM_WB_Write, Halted, Stall_timeout, StallCycles, FlushCount
  );

  modport slave (
    input  ID_stall, ID_PCSrc, MEM_busy, Halt_req,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write,
           EX_MEM_Write, MEM_WB_Write, Halted, Stall_timeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Per-core pipeline sequencer: prioritises memory wait, RAW stall, halt and
// branch redirect into register enables, runs the halt drain and perf counters.
module pipeline_hazard_sequencer #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_STALL    = 64
) (
  input  logic                          Clk,
  input  logic                          Reset,
  pipeline_hazard_sequencer_if.slave    hz
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD  = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [STALL_W-1:0] consec_q, consec_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               timeout_q, timeout_d;
  logic               halted_q;

  // Same-cycle controls; reset forces NOP/bubble injection with everything else frozen.
  always_comb begin
    hz.PC_Write     = 1'b0;
    hz.IF_ID_Write  = 1'b0;
    hz.IF_ID_Flush  = 1'b0;
    hz.ID_EX_Bubble = 1'b0;
    hz.ID_EX_Write  = 1'b0;
    hz.EX_MEM_Write = 1'b0;
    hz.MEM_WB_Write = 1'b0;
    if (Reset) begin
      hz.IF_ID_Flush  = 1'b1;
      hz.ID_EX_Bubble = 1'b1;
    end else if (!hz.MEM_busy) begin
      case (state_q)
        RUN: begin
          hz.ID_EX_Write  = 1'b1;
          hz.EX_MEM_Write = 1'b1;
          hz.MEM_WB_Write = 1'b1;
          if (hz.ID_stall) begin
            hz.ID_EX_Bubble = 1'b1;
          end else if (hz.Halt_req) begin
            hz.IF_ID_Write = 1'b1;
            hz.IF_ID_Flush = 1'b1;
          end else begin
            hz.PC_Write    = 1'b1;
            hz.IF_ID_Write = 1'b1;
            hz.IF_ID_Flush = hz.ID_PCSrc;
          end
        end
        DRAIN: begin
          hz.IF_ID_Flush  = 1'b1;
          hz.ID_EX_Bubble = 1'b1;
          hz.ID_EX_Write  = 1'b1;
          hz.EX_MEM_Write = 1'b1;
          hz.MEM_WB_Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state: a memory freeze holds every register, including the drain count.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    consec_d    = consec_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    if (!hz.MEM_busy) begin
      case (state_q)
        RUN: begin
          if (hz.ID_stall) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
            if (consec_q != STALL_LIMIT) consec_d = consec_q + 1'b1;
            if (consec_d == STALL_LIMIT) timeout_d = 1'b1;
          end else begin
            consec_d = '0;
            if (hz.Halt_req) begin
              state_d = DRAIN;
              drain_d = DRAIN_LOAD;
            end else if (hz.ID_PCSrc && flush_cnt_q != CNT_MAX) begin
              flush_cnt_d = flush_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          consec_d = '0;
          if (drain_q == '0) state_d = HALTED;
          else               drain_d = drain_q - 1'b1;
        end
        default: consec_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RUN;
      drain_q     <= '0;
      consec_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      consec_q    <= consec_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
      halted_q    <= (state_d == HALTED);
    end
  end

  assign hz.Halted        = halted_q;
  assign hz.Stall_timeout = timeout_q;
  assign hz.StallCycles   = stall_cnt_q;
  assign hz.FlushCount    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Randomised bench for pipeline_hazard_sequencer against a cycle-level
// behavioural model, plus directed scenarios pinned with literal values.
module tb_pipeline_hazard_sequencer;

  localparam int CW    = 4;
  localparam int DRAIN = 4;
  localparam int MAXST = 64;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cycleNum = 0;
  int   firstHalted = -1;

  // Model state: mode 0=running 1=draining 2=halted
  int   mMode, mDrainLeft, mStallCyc, mFlushCnt, mConsec;
  bit   mTimeout, mValid = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer_if #(.CNT_W(CW)) hz();

  pipeline_hazard_sequencer #(.CNT_W(CW), .DRAIN_CYCLES(DRAIN), .MAX_STALL(MAXST)) dut (
    .Clk   (clk),
    .Reset (rst),
    .hz    (hz)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycleNum, act, exp);
    end
  endtask

  // Expected controls packed as {PC, IFID_W, Flush, Bubble, IDEX_W, EXMEM_W, MEMWB_W}.
  function automatic logic [6:0] expControls();
    if (rst)         return 7'b0011000;
    if (hz.MEM_busy) return 7'b0000000;
    case (mMode)
      0: begin
        if (hz.ID_stall) return 7'b0001111;
        if (hz.Halt_req) return 7'b0110111;
        if (hz.ID_PCSrc) return 7'b1110111;
        return 7'b1100111;
      end
      1:       return 7'b0011111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput();
    logic [6:0] act;
    act = {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble,
           hz.ID_EX_Write, hz.EX_MEM_Write, hz.MEM_WB_Write};
    check("controls", {25'd0, act}, {25'd0, expControls()});
    if (mValid) begin
      check("Halted", {31'd0, hz.Halted}, {31'd0, mMode == 2});
      check("Stall_timeout", {31'd0, hz.Stall_timeout}, {31'd0, mTimeout});
      check("StallCycles", {28'd0, hz.StallCycles}, mStallCyc);
      check("FlushCount", {28'd0, hz.FlushCount}, mFlushCnt);
    end
    if (hz.Halted === 1'b1 && firstHalted < 0) firstHalted = cycleNum;
  endtask

  task automatic modelStep();
    if (rst) begin
      mMode = 0; mDrainLeft = 0; mStallCyc = 0; mFlushCnt = 0;
      mConsec = 0; mTimeout = 1'b0; mValid = 1'b1;
    end else if (!hz.MEM_busy) begin
      if (mMode == 0 && hz.ID_stall) begin
        mStallCyc = (mStallCyc < CMAX) ? mStallCyc + 1 : CMAX;
        mConsec   = (mConsec < MAXST) ? mConsec + 1 : MAXST;
        if (mConsec >= MAXST) mTimeout = 1'b1;
      end else begin
        mConsec = 0;
        if (mMode == 0 && hz.Halt_req) begin
          mMode = 1;
          mDrainLeft = DRAIN;
        end else if (mMode == 0 && hz.ID_PCSrc) begin
          mFlushCnt = (mFlushCnt < CMAX) ? mFlushCnt + 1 : CMAX;
        end else if (mMode == 1) begin
          mDrainLeft--;
          if (mDrainLeft == 0) mMode = 2;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit stall, input bit pcsrc,
                               input bit busy, input bit halt);
    rst = r;
    hz.ID_stall = stall;
    hz.ID_PCSrc = pcsrc;
    hz.MEM_busy = busy;
    hz.Halt_req = halt;
    @(negedge clk);
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
  endtask

  initial begin
    int reqCycle;
    rst = 1'b1;
    hz.ID_stall = 1'b0; hz.ID_PCSrc = 1'b0; hz.MEM_busy = 1'b0; hz.Halt_req = 1'b0;

    // Reset then idle running
    doReset();
    applyStimulus(0, 0, 0, 0, 0);
    check("idle PC_Write", {31'd0, hz.PC_Write}, 32'd1);
    check("idle Flush", {31'd0, hz.IF_ID_Flush}, 32'd0);
    check("reset StallCycles", {28'd0, hz.StallCycles}, 32'd0);
    check("reset Halted", {31'd0, hz.Halted}, 32'd0);

    // Stall masks a simultaneous redirect
    doReset();
    repeat (3) applyStimulus(0, 1, 1, 0, 0);
    check("stall StallCycles", {28'd0, hz.StallCycles}, 32'd3);
    check("stall FlushCount", {28'd0, hz.FlushCount}, 32'd0);

    // Redirect followed by memory freeze
    doReset();
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    check("freeze Flush", {31'd0, hz.IF_ID_Flush}, 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    check("branch FlushCount", {28'd0, hz.FlushCount}, 32'd1);

    // Halt with a one-cycle freeze in the middle of the drain
    doReset();
    firstHalted = -1;
    reqCycle = cycleNum;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0);
    check("halt latency", firstHalted - reqCycle, DRAIN + 2);

    // Stall watchdog trips after MAX_STALL consecutive stalls and is sticky
    doReset();
    repeat (MAXST - 1) applyStimulus(0, 1, 0, 0, 0);
    check("timeout before limit", {31'd0, hz.Stall_timeout}, 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    check("timeout at limit", {31'd0, hz.Stall_timeout}, 32'd1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    check("timeout sticky", {31'd0, hz.Stall_timeout}, 32'd1);
    check("StallCycles saturated", {28'd0, hz.StallCycles}, 32'd15);

    // Flush counter saturation, then reset aborts a drain
    doReset();
    repeat (20) applyStimulus(0, 0, 1, 0, 0);
    check("FlushCount saturated", {28'd0, hz.FlushCount}, 32'd15);
    applyStimulus(0, 0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("post-drain-reset Halted", {31'd0, hz.Halted}, 32'd0);
    check("post-drain-reset PC_Write", {31'd0, hz.PC_Write}, 32'd1);

    // Randomised traffic
    doReset();
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = (mMode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      applyStimulus(r,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
